// File: rtl/sevenseg_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment scan controller.
// Widths, parameter defaults and the active-low anode pattern helper.
package sevenseg_pkg;

  localparam int unsigned NIBBLE_W       = 4;
  localparam int unsigned MAX_DIGITS     = 8;
  localparam int unsigned NUM_DIGITS_DEF = 4;
  localparam int unsigned CLK_DIV_DEF    = 100000;
  localparam int unsigned DEAD_CYC_DEF   = 2;
  localparam int unsigned DIV_W_DEF      = 17;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  // Active-low one-hot over the widest supported display; callers truncate.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot_n(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler and digit index counter for the display scan.
// Both counters freeze while enable is low so the scan resumes where it stopped.
module scan_tick_gen #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned CLK_DIV    = 100000,
  parameter int unsigned DEAD_CYC   = 2,
  parameter int unsigned DIV_W      = 17,
  parameter int unsigned IDX_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             tick,
  output logic             boundary,
  output logic [IDX_W-1:0] idx,
  output logic             in_dead
);

  logic [DIV_W-1:0] prescaler_q;
  logic [IDX_W-1:0] idx_q;

  assign tick     = enable && (prescaler_q == DIV_W'(CLK_DIV - 1));
  assign boundary = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
  assign in_dead  = prescaler_q < DIV_W'(DEAD_CYC);
  assign idx      = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler_q <= '0;
      idx_q       <= '0;
    end else if (tick) begin
      prescaler_q <= '0;
      idx_q       <= boundary ? '0 : idx_q + IDX_W'(1);
    end else if (enable) begin
      prescaler_q <= prescaler_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Multiplexed 7-segment scan controller: double-buffered display word, frame-aligned
// updates, leading-zero blanking and per-slot dead time, all outputs registered.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned DEAD_CYC   = DEAD_CYC_DEF,
  parameter int unsigned DIV_W      = DIV_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
  input  logic                           lz_blank_en,
  output logic [NIBBLE_W-1:0]            num,
  output logic [NUM_DIGITS-1:0]          digit_sel,
  output logic                           digit_active,
  output logic                           frame_done
);

  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned WORD_W = NIBBLE_W * NUM_DIGITS;

  logic             tick;
  logic             boundary;
  logic [IDX_W-1:0] idx;
  logic             in_dead;

  scan_tick_gen #(
    .NUM_DIGITS (NUM_DIGITS),
    .CLK_DIV    (CLK_DIV),
    .DEAD_CYC   (DEAD_CYC),
    .DIV_W      (DIV_W),
    .IDX_W      (IDX_W)
  ) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .tick     (tick),
    .boundary (boundary),
    .idx      (idx),
    .in_dead  (in_dead)
  );

  logic [WORD_W-1:0] disp_q;
  logic [WORD_W-1:0] pend_q;
  logic              pend_full_q;
  logic              accept;
  logic              transfer;

  assign load_ready = ~pend_full_q;
  assign accept     = load_valid && !pend_full_q;
  // With the display dark there is no tearing risk, so a pending word moves at once.
  assign transfer   = pend_full_q && (boundary || !enable);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else if (transfer) begin
      disp_q      <= pend_q;
      pend_full_q <= 1'b0;
    end else if (accept) begin
      pend_q      <= load_data;
      pend_full_q <= 1'b1;
    end
  end

  logic [NUM_DIGITS-1:0] blanked;
  logic                  upper_zero;
  nibble_t               num_d;
  logic [NUM_DIGITS-1:0] digit_sel_d;

  always_comb begin
    blanked    = '0;
    upper_zero = lz_blank_en;
    // Walk down from the MSD; a digit blanks only if it and everything above it is zero.
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (disp_q[i*NIBBLE_W +: NIBBLE_W] == '0);
      blanked[i] = upper_zero;
    end
  end

  always_comb begin
    num_d = disp_q[NIBBLE_W*idx +: NIBBLE_W];
    if (!enable || in_dead || blanked[idx]) begin
      digit_sel_d = '1;
    end else begin
      digit_sel_d = NUM_DIGITS'(anode_onehot_n(3'(idx)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num          <= '0;
      digit_sel    <= '1;
      digit_active <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      num          <= num_d;
      digit_sel    <= digit_sel_d;
      digit_active <= ~&digit_sel_d;
      frame_done   <= boundary;
    end
  end

  a_boundary_on_tick : assert property (@(posedge clk) disable iff (!rst_n) boundary |-> tick);
  a_one_anode : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(~digit_sel));

endmodule

// File: tb/tb_sevenseg_scan.sv
// Randomized self-checking bench for sevenseg_scan against a time-based reference model.
module tb_sevenseg_scan;

  localparam int NDIG  = 4;
  localparam int CDIV  = 4;
  localparam int DEAD  = 1;
  localparam int DIVW  = 3;
  localparam int FRAME = NDIG * CDIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        lz_blank_en;
  logic [3:0]  num;
  logic [3:0]  digit_sel;
  logic        digit_active;
  logic        frame_done;

  sevenseg_scan #(
    .NUM_DIGITS (NDIG),
    .CLK_DIV    (CDIV),
    .DEAD_CYC   (DEAD),
    .DIV_W      (DIVW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .lz_blank_en  (lz_blank_en),
    .num          (num),
    .digit_sel    (digit_sel),
    .digit_active (digit_active),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: t counts enabled cycles since reset; slot and digit follow from division.
  int          t;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  bit          m_full;
  logic [3:0]  e_num;
  logic [3:0]  e_sel;
  bit          e_act;
  bit          e_fd;

  task automatic model_reset();
    t      = 0;
    m_disp = '0;
    m_pend = '0;
    m_full = 1'b0;
    e_num  = '0;
    e_sel  = 4'hF;
    e_act  = 1'b0;
    e_fd   = 1'b0;
  endtask

  task automatic apply(input bit en, input bit lv, input logic [15:0] ld, input bit lz);
    int  p;
    int  ix;
    bit  fd;
    bit  blank;
    enable      = en;
    load_valid  = lv;
    load_data   = ld;
    lz_blank_en = lz;
    p     = t % CDIV;
    ix    = (t / CDIV) % NDIG;
    fd    = en && ((t % FRAME) == FRAME - 1);
    blank = (ix > 0) && lz && ((m_disp >> (4 * ix)) == 16'h0);
    e_num = m_disp[4*ix +: 4];
    e_sel = (!en || p < DEAD || blank) ? 4'hF : (4'hF & ~(4'b0001 << ix));
    e_act = (e_sel != 4'hF);
    e_fd  = fd;
    if (m_full && (fd || !en)) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (lv && !m_full) begin
      m_pend = ld;
      m_full = 1'b1;
    end
    if (en) t++;
  endtask

  task automatic check_outputs();
    check("num", 32'(num), 32'(e_num));
    check("digit_sel", 32'(digit_sel), 32'(e_sel));
    check("digit_active", 32'(digit_active), 32'(e_act));
    check("frame_done", 32'(frame_done), 32'(e_fd));
    check("load_ready", 32'(load_ready), 32'(!m_full));
  endtask

  task automatic step(input bit en, input bit lv, input logic [15:0] ld, input bit lz);
    @(negedge clk);
    check_outputs();
    apply(en, lv, ld, lz);
  endtask

  task automatic rand_step(input bit lz);
    logic [15:0] w;
    w = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
    step($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, w, lz);
  endtask

  initial begin
    int guard;
    bit lz;
    rst_n       = 1'b0;
    enable      = 1'b0;
    load_valid  = 1'b0;
    load_data   = '0;
    lz_blank_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 16'h0, 1'b0);

    repeat (20) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h1234, 1'b0);
    repeat (40) step(1'b1, 1'b0, 16'h0, 1'b0);
    step(1'b1, 1'b1, 16'h0042, 1'b1);
    repeat (40) step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'h0000, 1'b1);
    repeat (40) step(1'b1, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b1, 16'hAAAA, 1'b0);
    repeat (40) step(1'b1, 1'b1, 16'hBBBB, 1'b0);
    repeat (20) step(1'b1, 1'b0, 16'h0, 1'b0);

    // Queue a word, then drop enable mid-slot on digit 2.
    step(1'b1, 1'b1, 16'h5678, 1'b0);
    guard = 0;
    while (!(((t / CDIV) % NDIG) == 2 && (t % CDIV) == 1) && guard < 64) begin
      step(1'b1, 1'b0, 16'h0, 1'b0);
      guard++;
    end
    check("wait_idx2", 32'(guard < 64), 32'd1);
    if (!m_full) step(1'b1, 1'b1, 16'h9ABC, 1'b0);
    repeat (5) step(1'b0, 1'b0, 16'h0, 1'b0);
    repeat (30) step(1'b1, 1'b0, 16'h0, 1'b0);

    lz = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 200 == 0) lz = $urandom_range(0, 1) == 1;
      rand_step(lz);
    end

    // Reset mid-slot with a word pending.
    guard = 0;
    while (!m_full && guard < 10) begin
      step(1'b1, 1'b1, 16'($urandom), 1'b0);
      guard++;
    end
    check("wait_pending", 32'(m_full), 32'd1);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b0;
    #1;
    check("rst_num", 32'(num), 32'd0);
    check("rst_digit_sel", 32'(digit_sel), 32'hF);
    check("rst_digit_active", 32'(digit_active), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_load_ready", 32'(load_ready), 32'd1);
    model_reset();
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    apply(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 200; i++) rand_step(1'b1);
    @(negedge clk);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
